// File: rtl/subleq_ctrl_pkg.sv
// Shared types and constants for the SUBLEQ sequencer: FSM state encoding,
// default geometry and instruction-field position helpers.
package subleq_ctrl_pkg;

    localparam int DEF_WORD_SIZE = 24;
    localparam int DEF_MEM_SIZE  = 256;
    localparam int DEF_ADDR_BITS = $clog2(DEF_MEM_SIZE);

    // An instruction word holds three equal-width fields {A, B, C}, A in the top slice.
    localparam int N_ARGS = 3;
    localparam int ARG_C  = 0;
    localparam int ARG_B  = 1;
    localparam int ARG_A  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_BRANCH,
        S_HALT
    } ctrl_state_e;

    function automatic int arg_low_bound(input int word_size, input int arg);
        return arg * (word_size / N_ARGS);
    endfunction

    function automatic int arg_up_bound(input int word_size, input int arg);
        return arg_low_bound(word_size, arg) + (word_size / N_ARGS) - 1;
    endfunction

endpackage

// File: rtl/subleq_dbg_port.sv
// Port-1 arbiter: lets the debug/loader requester take memory port 1 whenever
// the sequencer is at an instruction boundary, and returns read data one cycle later.
module subleq_dbg_port
    import subleq_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arb_ok,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [WORD_SIZE-1:0] dbg_addr,
    input  logic [WORD_SIZE-1:0] dbg_wdata,
    input  logic [WORD_SIZE-1:0] core_add1,
    input  logic [WORD_SIZE-1:0] core_din1,
    input  logic                 core_we1,
    input  logic [WORD_SIZE-1:0] mem_dout1,
    output logic [WORD_SIZE-1:0] mem_add1,
    output logic [WORD_SIZE-1:0] mem_din1,
    output logic                 mem_we1,
    output logic                 dbg_gnt,
    output logic                 dbg_rvalid,
    output logic [WORD_SIZE-1:0] dbg_rdata
);

    localparam logic [WORD_SIZE-1:0] ADDR_MASK = WORD_SIZE'((64'd1 << ADDR_BITS) - 64'd1);

    logic rvalid_q, rvalid_d;

    // Nothing reaches the memory during the reset cycle, whoever owns the port.
    assign dbg_gnt    = arb_ok & dbg_req & ~rst;
    assign mem_add1   = dbg_gnt ? (dbg_addr & ADDR_MASK) : core_add1;
    assign mem_din1   = dbg_gnt ? dbg_wdata : core_din1;
    assign mem_we1    = dbg_gnt ? dbg_we : (core_we1 & ~rst);
    assign rvalid_d   = dbg_gnt & ~dbg_we;
    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = mem_dout1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ core sequencer: single-clock FSM stepping fetch / operand read /
// write-back / branch over a dual-port synchronous memory, with debug access.
module subleq_ctrl
    import subleq_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int MEM_SIZE  = DEF_MEM_SIZE,
    parameter int RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] pc_o,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [WORD_SIZE-1:0] dbg_addr,
    input  logic [WORD_SIZE-1:0] dbg_wdata,
    output logic                 dbg_gnt,
    output logic                 dbg_rvalid,
    output logic [WORD_SIZE-1:0] dbg_rdata,
    output logic [WORD_SIZE-1:0] mem_add1,
    output logic [WORD_SIZE-1:0] mem_din1,
    output logic                 mem_we1,
    output logic [WORD_SIZE-1:0] mem_add2,
    output logic [WORD_SIZE-1:0] mem_din2,
    output logic                 mem_we2,
    input  logic [WORD_SIZE-1:0] mem_dout1,
    input  logic [WORD_SIZE-1:0] mem_dout2
);

    localparam int ADDR_BITS = $clog2(MEM_SIZE);
    localparam int A_LO      = arg_low_bound(WORD_SIZE, ARG_A);
    localparam int B_LO      = arg_low_bound(WORD_SIZE, ARG_B);
    localparam int C_LO      = arg_low_bound(WORD_SIZE, ARG_C);
    localparam int FIELD_W   = arg_up_bound(WORD_SIZE, ARG_A) - A_LO + 1;

    localparam logic [WORD_SIZE-1:0] ADDR_MASK  = WORD_SIZE'((64'd1 << ADDR_BITS) - 64'd1);
    localparam logic [WORD_SIZE-1:0] FIELD_MASK = WORD_SIZE'((64'd1 << FIELD_W) - 64'd1);
    localparam logic [WORD_SIZE-1:0] RESET_PC_W = WORD_SIZE'(RESET_PC) & ADDR_MASK;

    // Out-of-range fields alias into the memory by dropping the high address bits.
    function automatic logic [WORD_SIZE-1:0] arg_addr(input logic [WORD_SIZE-1:0] w,
                                                      input int lo);
        return (w >> lo) & FIELD_MASK & ADDR_MASK;
    endfunction

    ctrl_state_e          state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] ir_q, ir_d;
    logic [WORD_SIZE-1:0] acc_q, acc_d;
    logic                 step_prev_q, step_prev_d;
    logic                 step_pend_q, step_pend_d;

    logic                 step_rise;
    logic                 taken;
    logic [WORD_SIZE-1:0] diff;
    logic [WORD_SIZE-1:0] branch_tgt;
    logic [WORD_SIZE-1:0] core_add1;
    logic [WORD_SIZE-1:0] core_din1;
    logic                 core_we1;
    logic                 arb_ok;

    assign step_rise  = step & ~step_prev_q;
    assign diff       = mem_dout1 - mem_dout2;
    assign taken      = acc_q[WORD_SIZE-1] | (acc_q == '0);
    assign branch_tgt = arg_addr(ir_q, C_LO);
    assign arb_ok     = (state_q == S_IDLE) | (state_q == S_HALT);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        step_prev_d = step;
        step_pend_d = step_pend_q;
        core_add1   = '0;
        core_din1   = '0;
        core_we1    = 1'b0;
        mem_add2    = '0;

        // A step edge seen while stopped is remembered until the next boundary.
        if (step_rise && !run) begin
            step_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!dbg_req && (run || step_rise || step_pend_q)) begin
                    state_d     = S_FETCH;
                    step_pend_d = 1'b0;
                end
            end
            S_FETCH: begin
                core_add1 = pc_q;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ir_d      = mem_dout1;
                core_add1 = arg_addr(mem_dout1, B_LO);
                mem_add2  = arg_addr(mem_dout1, A_LO);
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                acc_d     = diff;
                core_we1  = 1'b1;
                core_add1 = arg_addr(ir_q, B_LO);
                core_din1 = diff;
                state_d   = S_BRANCH;
            end
            S_BRANCH: begin
                if (taken) begin
                    pc_d    = branch_tgt;
                    state_d = (branch_tgt == pc_q) ? S_HALT : S_IDLE;
                end else begin
                    pc_d    = (pc_q + WORD_SIZE'(1)) & ADDR_MASK;
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                step_pend_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC_W;
            ir_q        <= '0;
            acc_q       <= '0;
            step_prev_q <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            step_prev_q <= step_prev_d;
            step_pend_q <= step_pend_d;
        end
    end

    assign halted   = (state_q == S_HALT) |
                      ((state_q == S_IDLE) & ~run & ~step_pend_q);
    assign pc_o     = pc_q;
    assign mem_din2 = '0;
    assign mem_we2  = 1'b0;

    subleq_dbg_port #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_dbg_port (
        .clk        (clk),
        .rst        (rst),
        .arb_ok     (arb_ok),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .core_add1  (core_add1),
        .core_din1  (core_din1),
        .core_we1   (core_we1),
        .mem_dout1  (mem_dout1),
        .mem_add1   (mem_add1),
        .mem_din1   (mem_din1),
        .mem_we1    (mem_we1),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata)
    );

endmodule

// File: tb/tb_subleq_ctrl.sv
// Directed bench for subleq_ctrl: a table of single-instruction vectors plus
// hand-written run, debug, reset-abort and pc-wrap sequences.
module tb_subleq_ctrl;
    import subleq_ctrl_pkg::*;

    localparam int WS = 24;
    localparam int MS = 64;

    logic          clk = 1'b0;
    logic          rst, run, step, halted;
    logic [WS-1:0] pc_o;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [WS-1:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [WS-1:0] mem_add1, mem_din1, mem_add2, mem_din2, mem_dout1, mem_dout2;
    logic          mem_we1, mem_we2;

    logic          ld_en = 1'b0;
    logic [5:0]    ld_addr = '0;
    logic [WS-1:0] ld_data = '0;
    logic [WS-1:0] mem [MS];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    subleq_ctrl #(.WORD_SIZE(WS), .MEM_SIZE(MS), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .halted(halted), .pc_o(pc_o),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_add1(mem_add1), .mem_din1(mem_din1), .mem_we1(mem_we1),
        .mem_add2(mem_add2), .mem_din2(mem_din2), .mem_we2(mem_we2),
        .mem_dout1(mem_dout1), .mem_dout2(mem_dout2)
    );

    // Dual-port synchronous RAM with a backdoor load port for the bench.
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_we1) mem[mem_add1[5:0]] <= mem_din1;
        mem_dout1 <= mem[mem_add1[5:0]];
        mem_dout2 <= mem[mem_add2[5:0]];
    end

    task automatic check(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WS-1:0] ins(input int a, input int b, input int c);
        return {8'(a), 8'(b), 8'(c)};
    endfunction

    task automatic poke(input int a, input logic [WS-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 6'(a); ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; run = 1'b0; step = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step_once;
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic dbg_xfer(input logic we, input int addr, input logic [WS-1:0] wd,
                            output int waited, output logic granted);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = WS'(addr); dbg_wdata = wd;
        waited = 0; granted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (dbg_gnt) begin
                granted = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        if (granted) begin
            @(posedge clk);
            @(negedge clk);
        end
        dbg_req = 1'b0; dbg_we = 1'b0;
        #1;
    endtask

    typedef struct {
        int            a, b, c;
        logic [WS-1:0] va, vb;
        logic [WS-1:0] exp_b;
        int            exp_pc;
        ctrl_state_e   exp_state;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        logic        granted;

        vecs[0] = '{10, 11, 0,  24'd3,       24'd5,       24'd2,       1, S_IDLE};
        vecs[1] = '{10, 11, 7,  24'd3,       24'd3,       24'd0,       7, S_IDLE};
        vecs[2] = '{10, 11, 7,  24'd5,       24'd3,       24'hFFFFFE,  7, S_IDLE};
        vecs[3] = '{12, 13, 0,  24'd1,       24'd1,       24'd0,       0, S_HALT};
        vecs[4] = '{14, 14, 9,  24'd42,      24'd42,      24'd0,       9, S_IDLE};
        vecs[5] = '{74, 75, 3,  24'd2,       24'd9,       24'd7,       1, S_IDLE};
        vecs[6] = '{10, 11, 5,  24'd1,       24'h800000,  24'h7FFFFF,  1, S_IDLE};
        vecs[7] = '{10, 11, 5,  24'h800000,  24'd0,       24'h800000,  5, S_IDLE};
        vecs[8] = '{10, 11, 70, 24'd1,       24'd0,       24'hFFFFFF,  6, S_IDLE};

        rst = 1'b0; run = 1'b0; step = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

        // Reset values and a stopped core staying put.
        do_reset;
        #1;
        check("rst_pc", pc_o, 0);
        check("rst_halted", WS'(halted), 1);
        check("rst_gnt", WS'(dbg_gnt), 0);
        check("rst_rvalid", WS'(dbg_rvalid), 0);
        check("rst_we1", WS'(mem_we1), 0);
        check("rst_we2", WS'(mem_we2), 0);
        poke(0, ins(10, 11, 0));
        poke(1, ins(12, 12, 0));
        poke(10, 3);
        poke(11, 5);
        repeat (6) @(negedge clk);
        check("frozen_pc", pc_o, 0);
        check("frozen_mem11", mem[11], 5);

        // Step held high for many cycles runs exactly one instruction.
        @(negedge clk); step = 1'b1;
        @(negedge clk);
        check("step_busy_halted", WS'(halted), 0);
        repeat (11) @(negedge clk);
        step = 1'b0;
        check("step_hold_pc", pc_o, 1);
        check("step_hold_mem11", mem[11], 2);
        check("step_hold_halted", WS'(halted), 1);

        // Table of single-instruction vectors, each from a fresh reset at pc 0.
        for (int i = 0; i < 9; i++) begin
            do_reset;
            poke(0, ins(vecs[i].a, vecs[i].b, vecs[i].c));
            poke(vecs[i].a % MS, vecs[i].va);
            poke(vecs[i].b % MS, vecs[i].vb);
            step_once;
            check($sformatf("vec%0d_memb", i), mem[vecs[i].b % MS], vecs[i].exp_b);
            check($sformatf("vec%0d_pc", i), pc_o, WS'(vecs[i].exp_pc));
            check($sformatf("vec%0d_state", i), WS'(dut.state_q), WS'(vecs[i].exp_state));
            check($sformatf("vec%0d_halted", i), WS'(halted), 1);
        end

        // Continuous run: 5 cycles per instruction, then a self-loop halts at pc 4.
        do_reset;
        poke(0, ins(10, 11, 0));
        poke(1, ins(12, 12, 4));
        poke(4, ins(12, 12, 4));
        poke(10, 3);
        poke(11, 5);
        @(negedge clk); run = 1'b1;
        repeat (5) @(negedge clk);
        check("run_i1_pc", pc_o, 1);
        check("run_i1_mem11", mem[11], 2);
        check("run_idle_halted", WS'(halted), 0);
        repeat (5) @(negedge clk);
        check("run_i2_pc", pc_o, 4);
        repeat (5) @(negedge clk);
        check("run_halt_halted", WS'(halted), 1);
        check("run_halt_pc", pc_o, 4);
        repeat (5) @(negedge clk);
        check("run_halt_stay_pc", pc_o, 4);
        check("run_halt_stay_halted", WS'(halted), 1);
        dbg_xfer(1'b0, 11, '0, waited, granted);
        check("halt_rd_gnt", WS'(granted), 1);
        check("halt_rd_rvalid", WS'(dbg_rvalid), 1);
        check("halt_rd_data", dbg_rdata, 2);
        run = 1'b0;

        // Debug write raised during EXEC waits for the boundary, then reads back.
        do_reset;
        poke(0, ins(10, 11, 0));
        poke(10, 3);
        poke(11, 5);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dbg_xfer(1'b1, 20, 24'hAB, waited, granted);
        check("dbgw_gnt", WS'(granted), 1);
        check("dbgw_wait", WS'(waited), 2);
        check("dbgw_no_rvalid", WS'(dbg_rvalid), 0);
        check("dbgw_mem20", mem[20], 24'hAB);
        check("dbgw_instr_mem11", mem[11], 2);
        dbg_xfer(1'b0, 20, '0, waited, granted);
        check("dbgr_gnt", WS'(granted), 1);
        check("dbgr_wait", WS'(waited), 0);
        check("dbgr_rvalid", WS'(dbg_rvalid), 1);
        check("dbgr_data", dbg_rdata, 24'hAB);
        check("dbgr_pc", pc_o, 1);

        // Reset during EXEC aborts the instruction with no write.
        do_reset;
        poke(0, ins(10, 11, 0));
        poke(1, ins(10, 11, 0));
        poke(10, 3);
        poke(11, 5);
        step_once;
        check("abort_pre_pc", pc_o, 1);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_we1", WS'(mem_we1), 0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("abort_mem11", mem[11], 2);
        check("abort_pc", pc_o, 0);
        check("abort_halted", WS'(halted), 1);

        // Not-taken branch at the last address wraps the pc to 0.
        do_reset;
        poke(0, ins(12, 12, 63));
        poke(63, ins(10, 11, 5));
        poke(10, 3);
        poke(11, 5);
        step_once;
        check("wrap_jump_pc", pc_o, 63);
        step_once;
        check("wrap_pc", pc_o, 0);
        check("wrap_mem11", mem[11], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
